// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator feeding the Sobel Gradient stage (P0..P8 one-to-one).
// Latency: window completed by pixel (r,c) is on P0..P8 with win_valid one clk after acceptance.
// Backpressure: none; pix_valid=0 stalls all state, outputs hold, win_valid/win_last low.
module sobel_window_gen #(
    parameter int nbit  = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [nbit-1:0] pix_in,
    input  logic            pix_valid,
    input  logic            sof,
    output logic [nbit-1:0] P0,
    output logic [nbit-1:0] P1,
    output logic [nbit-1:0] P2,
    output logic [nbit-1:0] P3,
    output logic [nbit-1:0] P4,
    output logic [nbit-1:0] P5,
    output logic [nbit-1:0] P6,
    output logic [nbit-1:0] P7,
    output logic [nbit-1:0] P8,
    output logic            win_valid,
    output logic            win_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]   col, cur_col, nxt_col;
    logic [RW-1:0]   row, cur_row, nxt_row;
    logic [nbit-1:0] line_a [0:IMG_W-1];
    logic [nbit-1:0] line_b [0:IMG_W-1];
    logic [nbit-1:0] rd_a, rd_b;
    logic [nbit-1:0] win [0:8];

    // sof re-anchors the current beat at (0,0); counting continues from there
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        nxt_col = cur_col + CW'(1);
        nxt_row = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    assign rd_a = line_a[cur_col];
    assign rd_b = line_b[cur_col];

    // Line storage is RAM-like and never reset; its contents are masked until row 2
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            line_a[cur_col] <= pix_in;
            line_b[cur_col] <= rd_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int k = 0; k < 9; k++) win[k] <= '0;
        end else begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (pix_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= rd_b;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= rd_a;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pix_in;
                // columns 0/1 still carry the previous row's tail, so they never qualify
                win_valid <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
                win_last  <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            end
        end
    end

    assign P0 = win[0];
    assign P1 = win[1];
    assign P2 = win[2];
    assign P3 = win[3];
    assign P4 = win[4];
    assign P5 = win[5];
    assign P6 = win[6];
    assign P7 = win[7];
    assign P8 = win[8];

endmodule
